booth_multiplier: RTL and testbench

Sequential radix-2 Booth multiplier for two's-complement operands. Accepts two signed n-bit operands on a start strobe, iterates one Booth step per clock, and returns the exact signed 2n-bit product with a one-cycle done pulse. It serves as a shared arithmetic unit for datapaths that can tolerate multi-cycle latency in exchange for low area.

---
 rtl/booth_multiplier.sv | 122 ++++++++++++
 tb/tb_booth_multiplier.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/booth_multiplier.sv
// booth_multiplier: sequential radix-2 Booth multiplier.
// Accepts two signed n-bit operands on a start strobe, performs one Booth
// step per clock and delivers the exact signed 2n-bit product together with
// a single-cycle done pulse. An (n+1)-bit accumulator keeps the most
// negative multiplicand exact, so no overflow case exists.
module booth_multiplier #(
   parameter int n = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [n-1:0]     M,
   input  logic [n-1:0]     Q,
   output logic [2*n-1:0]   P,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(n + 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]     state_q, state_d;
   logic [n:0]     a_q, a_d;        // sign-extended accumulator
   logic [n:0]     mr_q, mr_d;      // sign-extended multiplicand
   logic [n-1:0]   qr_q, qr_d;      // multiplier / low product half
   logic           q1_q, q1_d;      // Booth history bit
   logic [CW-1:0]  cnt_q, cnt_d;    // remaining Booth steps
   logic [2*n-1:0] p_q, p_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   logic [n:0]     a_sum;
   logic [n:0]     a_sh;
   logic [n-1:0]   qr_sh;

   // Booth add/subtract followed by the arithmetic right shift of {A,Qr,q_1}
   always_comb begin
      a_sum = a_q;
      case ({qr_q[0], q1_q})
         2'b01:   a_sum = a_q + mr_q;
         2'b10:   a_sum = a_q - mr_q;
         default: a_sum = a_q;
      endcase
      a_sh  = {a_sum[n], a_sum[n:1]};
      qr_sh = {a_sum[0], qr_q[n-1:1]};
   end

   // Next-state logic: operand capture in IDLE, one Booth step per RUN cycle
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      mr_d    = mr_q;
      qr_d    = qr_q;
      q1_d    = q1_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = '0;
               qr_d    = Q;
               q1_d    = 1'b0;
               mr_d    = {M[n-1], M};
               cnt_d   = CW'(n);
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d   = a_sh;
            qr_d  = qr_sh;
            q1_d  = qr_q[0];
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               // Final step: the product is the low 2n bits of {A,Qr}
               p_d     = {a_sh[n-1:0], qr_sh};
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset abandons any operation in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         mr_q    <= '0;
         qr_q    <= '0;
         q1_q    <= 1'b0;
         cnt_q   <= '0;
         p_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         mr_q    <= mr_d;
         qr_q    <= qr_d;
         q1_q    <= q1_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign P    = p_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed bench for booth_multiplier: reset, signs, extremes, busy
// protection, back-to-back operation and random pairs at n=10 and n=4.
module tb_booth_multiplier;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  M = '0;
   logic [9:0]  Q = '0;
   logic [19:0] P;
   logic        busy;
   logic        done;

   logic        start4 = 1'b0;
   logic [3:0]  M4 = '0;
   logic [3:0]  Q4 = '0;
   logic [7:0]  P4;
   logic        busy4;
   logic        done4;

   int n_vec = 0;
   int n_err = 0;

   booth_multiplier #(.n(10)) dut (
      .clk(clk), .rst(rst), .start(start), .M(M), .Q(Q),
      .P(P), .busy(busy), .done(done)
   );

   booth_multiplier #(.n(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .M(M4), .Q(Q4),
      .P(P4), .busy(busy4), .done(done4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One n=10 operation with full done/busy timing checks.
   task automatic run_op(input string tag, input logic signed [9:0] m,
                         input logic signed [9:0] q, input longint exp);
      int bad;
      bad = 0;
      @(negedge clk);
      start = 1'b1; M = m; Q = q;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_busy_rise"}, busy, 1);
      chk({tag, "_done_low"}, done, 0);
      M = 10'($urandom); Q = 10'($urandom);   // must not disturb the run
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (i < 10 && (done !== 1'b0 || busy !== 1'b1)) bad++;
      end
      chk({tag, "_midrun"}, bad, 0);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy_fall"}, busy, 0);
      chk({tag, "_P"}, $signed(P), exp);
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_P_hold"}, $signed(P), exp);
   endtask

   // One n=4 operation; done must appear exactly 4 edges after acceptance.
   task automatic run4(input logic signed [3:0] m, input logic signed [3:0] q);
      int early;
      early = 0;
      @(negedge clk);
      start4 = 1'b1; M4 = m; Q4 = q;
      @(posedge clk); #1;
      start4 = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         if (i < 4 && done4 !== 1'b0) early++;
      end
      chk("n4_early_done", early, 0);
      chk("n4_done", done4, 1);
      chk("n4_P", $signed(P4), longint'(m) * longint'(q));
   endtask

   initial begin
      int pulses;
      logic signed [9:0] rm, rq;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_P", P, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      @(negedge clk);
      rst = 1'b0;

      // Basic signs
      run_op("zero", 10'sd0, 10'sd0, 0);
      run_op("neg_pos", -10'sd4, 10'sd14, -56);
      run_op("pos_pos", 10'sd218, 10'sd100, 21800);
      run_op("neg_neg", -10'sd100, -10'sd400, 40000);

      // Asynchronous reset mid-run (P currently 40000)
      @(negedge clk);
      start = 1'b1; M = 10'sd5; Q = 10'sd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("arst_P", P, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (done === 1'b1) pulses++;
      end
      chk("arst_no_done", pulses, 0);
      chk("arst_P_hold", P, 0);

      // Extremes
      run_op("min_min", -10'sd512, -10'sd512, 262144);
      run_op("max_min", 10'sd511, -10'sd512, -261632);
      run_op("min_one", -10'sd512, 10'sd1, -512);

      // Busy protection: a second start 4 cycles in is ignored
      @(negedge clk);
      start = 1'b1; M = -10'sd4; Q = 10'sd14;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1; M = 10'sd3; Q = 10'sd3;
      @(posedge clk); #1;
      start = 1'b0;
      pulses = 0;
      for (int i = 5; i <= 10; i++) begin
         @(posedge clk); #1;
         if (i < 10 && done === 1'b1) pulses++;
      end
      chk("busy_done", done, 1);
      chk("busy_P", $signed(P), -56);
      repeat (14) begin
         @(posedge clk); #1;
         if (done === 1'b1) pulses++;
      end
      chk("busy_extra_done", pulses, 0);
      chk("busy_idle", busy, 0);

      // Back-to-back with start held high
      @(negedge clk);
      start = 1'b1; M = 10'sd218; Q = 10'sd100;
      @(posedge clk); #1;
      M = -10'sd100; Q = -10'sd400;
      repeat (10) @(posedge clk);
      #1;
      chk("b2b_done1", done, 1);
      chk("b2b_P1", $signed(P), 21800);
      @(posedge clk); #1;
      chk("b2b_done_drop", done, 0);
      chk("b2b_busy_rise", busy, 1);
      repeat (10) @(posedge clk);
      #1;
      start = 1'b0;
      chk("b2b_done2", done, 1);
      chk("b2b_P2", $signed(P), 40000);
      @(posedge clk); #1;
      chk("b2b_stop", busy, 0);

      // Random pairs, n=10
      for (int k = 0; k < 1000; k++) begin
         rm = 10'($urandom);
         rq = 10'($urandom);
         run_op("rand10", rm, rq, longint'(rm) * longint'(rq));
      end

      // Random pairs, n=4
      for (int k = 0; k < 1000; k++) begin
         run4(4'($urandom), 4'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
